// File: rtl/fir_ctrl_mc_if.sv
// Handshake and datapath-control bundle for the multi-channel FIR controller.
// master = controller side, slave = source/sink/datapath side.
interface fir_ctrl_mc_if #(
    parameter int AW = 7,
    parameter int CW = 1
);
    logic          in_valid;
    logic          in_ready;
    logic          out_ready;
    logic          out_valid;
    logic [CW-1:0] out_ch;
    logic          dp_rst;
    logic          shift_enb;
    logic [CW-1:0] ch_sel;
    logic [AW-1:0] tap_addr;
    logic          acc_clr;
    logic          mac_enb;
    logic          last_tap;
    logic          busy;

    modport master (
        input  in_valid, out_ready,
        output in_ready, out_valid, out_ch, dp_rst, shift_enb,
        output ch_sel, tap_addr, acc_clr, mac_enb, last_tap, busy
    );

    modport slave (
        output in_valid, out_ready,
        input  in_ready, out_valid, out_ch, dp_rst, shift_enb,
        input  ch_sel, tap_addr, acc_clr, mac_enb, last_tap, busy
    );
endinterface

// File: rtl/fir_ctrl_mc.sv
// Multi-channel sequencer for a time-multiplexed single-MAC FIR datapath.
// Owns the tap counter and the round-robin channel pointer.
module fir_ctrl_mc #(
    parameter int TAPS     = 100,
    parameter int CHANNELS = 1,
    parameter int AW       = 7,
    parameter int CW       = 1
) (
    input  logic          clk,
    input  logic          cu_rst,
    fir_ctrl_mc_if.master bus
);
    typedef enum logic [1:0] {
        S_RESET,
        S_IDLE,
        S_CALC,
        S_DONE
    } state_t;

    localparam logic [AW-1:0] TAP_LAST = AW'(TAPS - 1);
    localparam logic [CW-1:0] CH_LAST  = CW'(CHANNELS - 1);

    state_t        state_q, state_d;
    logic [AW-1:0] tap_q, tap_d;
    logic [CW-1:0] ch_q, ch_d;

    always_ff @(posedge clk or posedge cu_rst) begin
        if (cu_rst) begin
            state_q <= S_RESET;
            tap_q   <= '0;
            ch_q    <= '0;
        end else begin
            state_q <= state_d;
            tap_q   <= tap_d;
            ch_q    <= ch_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        tap_d         = tap_q;
        ch_d          = ch_q;
        bus.dp_rst    = 1'b0;
        bus.acc_clr   = 1'b0;
        bus.in_ready  = 1'b0;
        bus.shift_enb = 1'b0;
        bus.mac_enb   = 1'b0;
        bus.last_tap  = 1'b0;
        bus.out_valid = 1'b0;
        bus.busy      = 1'b0;
        unique case (state_q)
            S_RESET: begin
                bus.dp_rst  = 1'b1;
                bus.acc_clr = 1'b1;
                tap_d       = '0;
                state_d     = S_IDLE;
            end
            S_IDLE: begin
                bus.in_ready = 1'b1;
                bus.acc_clr  = 1'b1;
                if (bus.in_valid) begin
                    bus.shift_enb = 1'b1;
                    tap_d         = '0;
                    state_d       = S_CALC;
                end
            end
            S_CALC: begin
                bus.mac_enb = 1'b1;
                bus.busy    = 1'b1;
                if (tap_q == TAP_LAST) begin
                    bus.last_tap = 1'b1;
                    tap_d        = '0;
                    state_d      = S_DONE;
                end else begin
                    tap_d = tap_q + AW'(1);
                end
            end
            S_DONE: begin
                bus.out_valid = 1'b1;
                bus.busy      = 1'b1;
                if (bus.out_ready) begin
                    state_d = S_IDLE;
                    // explicit wrap so non-power-of-two channel counts work
                    ch_d = (ch_q == CH_LAST) ? '0 : ch_q + CW'(1);
                end
            end
            default: state_d = S_RESET;
        endcase
    end

    assign bus.tap_addr = tap_q;
    assign bus.ch_sel   = ch_q;
    assign bus.out_ch   = ch_q;
endmodule

// File: tb/tb_fir_ctrl_mc.sv
// Directed bench: table-driven cycle vectors on a TAPS=4 instance plus
// hand sequences on TAPS=3/CH=3, TAPS=8/CH=2 and TAPS=1/CH=2 instances.
module tb_fir_ctrl_mc;
    logic clk = 1'b0;
    logic rst_a = 1'b1, rst_b = 1'b1, rst_c = 1'b1, rst_d = 1'b1;
    int   n_run = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    fir_ctrl_mc_if #(.AW(7), .CW(1)) ifa ();
    fir_ctrl_mc_if #(.AW(7), .CW(2)) ifb ();
    fir_ctrl_mc_if #(.AW(7), .CW(1)) ifc ();
    fir_ctrl_mc_if #(.AW(7), .CW(1)) ifd ();

    fir_ctrl_mc #(.TAPS(4), .CHANNELS(1), .AW(7), .CW(1))
        dut_a (.clk(clk), .cu_rst(rst_a), .bus(ifa.master));
    fir_ctrl_mc #(.TAPS(3), .CHANNELS(3), .AW(7), .CW(2))
        dut_b (.clk(clk), .cu_rst(rst_b), .bus(ifb.master));
    fir_ctrl_mc #(.TAPS(8), .CHANNELS(2), .AW(7), .CW(1))
        dut_c (.clk(clk), .cu_rst(rst_c), .bus(ifc.master));
    fir_ctrl_mc #(.TAPS(1), .CHANNELS(2), .AW(7), .CW(1))
        dut_d (.clk(clk), .cu_rst(rst_d), .bus(ifd.master));

    localparam logic [7:0] IR = 8'h80, SH = 8'h40, MC = 8'h20, LT = 8'h10;
    localparam logic [7:0] OV = 8'h08, BZ = 8'h04, DP = 8'h02, AC = 8'h01;

    typedef struct packed {
        logic       iv;
        logic       ordy;
        logic [7:0] fl;
        logic [6:0] tap;
    } vec_t;

    vec_t vq[$];

    task automatic chk(input string name, input int act, input int exp);
        n_run++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic int flags_a();
        return int'({ifa.in_ready, ifa.shift_enb, ifa.mac_enb,
                     ifa.last_tap, ifa.out_valid, ifa.busy,
                     ifa.dp_rst, ifa.acc_clr});
    endfunction

    function automatic void add(logic iv, logic ordy,
                                logic [7:0] fl, logic [6:0] tap);
        vec_t v;
        v.iv = iv;
        v.ordy = ordy;
        v.fl = fl;
        v.tap = tap;
        vq.push_back(v);
    endfunction

    initial begin
        int cyc;
        int nres;
        int chs[4];
        int cys[4];
        int acc_cyc[$];
        int dch[$];
        int rises;
        logic prev_ov;

        ifa.in_valid = 0; ifa.out_ready = 0;
        ifb.in_valid = 0; ifb.out_ready = 0;
        ifc.in_valid = 0; ifc.out_ready = 0;
        ifd.in_valid = 0; ifd.out_ready = 0;

        // A: reset, idle, accept, calc, done with immediate and held sink
        add(0, 0, DP | AC, 0);
        for (int i = 0; i < 10; i++) add(0, 0, IR | AC, 0);
        add(1, 1, IR | SH | AC, 0);
        add(1, 1, MC | BZ, 0);
        add(0, 1, MC | BZ, 1);
        add(1, 1, MC | BZ, 2);
        add(0, 1, MC | BZ | LT, 3);
        add(0, 1, OV | BZ, 0);
        add(1, 0, IR | SH | AC, 0);
        add(0, 0, MC | BZ, 0);
        add(0, 0, MC | BZ, 1);
        add(0, 0, MC | BZ, 2);
        add(0, 0, MC | BZ | LT, 3);
        for (int i = 0; i < 7; i++) add(i[0], 0, OV | BZ, 0);
        add(0, 1, OV | BZ, 0);
        add(0, 0, IR | AC, 0);

        @(negedge clk);
        #1;
        chk("rst_flags", flags_a(), int'(DP | AC));
        chk("rst_tap", int'(ifa.tap_addr), 0);
        chk("rst_ch", int'({ifa.ch_sel, ifa.out_ch}), 0);

        for (int i = 0; i < vq.size(); i++) begin
            @(negedge clk);
            if (i == 0) begin
                rst_a = 0; rst_b = 0; rst_c = 0; rst_d = 0;
            end
            ifa.in_valid = vq[i].iv;
            ifa.out_ready = vq[i].ordy;
            #1;
            chk($sformatf("a_vec%0d_flags", i), flags_a(), int'(vq[i].fl));
            chk($sformatf("a_vec%0d_tap", i),
                int'(ifa.tap_addr), int'(vq[i].tap));
            chk($sformatf("a_vec%0d_och", i), int'(ifa.out_ch), 0);
        end
        ifa.in_valid = 0;

        // B: four back-to-back samples over three channels
        ifb.in_valid = 1;
        ifb.out_ready = 1;
        nres = 0;
        for (cyc = 0; cyc < 60 && nres < 4; cyc++) begin
            @(negedge clk);
            #1;
            if (ifb.out_valid) begin
                chs[nres] = int'(ifb.out_ch);
                cys[nres] = cyc;
                nres++;
            end
        end
        ifb.in_valid = 0;
        chk("b_results", nres, 4);
        chk("b_och0", chs[0], 0);
        chk("b_och1", chs[1], 1);
        chk("b_och2", chs[2], 2);
        chk("b_och3", chs[3], 0);
        chk("b_period", cys[3] - cys[2], 5);

        // C: one full result to move ch_sel, then reset mid-CALC
        ifc.in_valid = 1;
        ifc.out_ready = 1;
        for (cyc = 0; cyc < 30 && !ifc.out_valid; cyc++) begin
            @(negedge clk);
            #1;
        end
        ifc.in_valid = 0;
        chk("c_first_result", int'(ifc.out_valid), 1);
        @(negedge clk);
        #1;
        chk("c_ch_adv", int'(ifc.ch_sel), 1);
        ifc.in_valid = 1;
        @(negedge clk);
        ifc.in_valid = 0;
        #1;
        chk("c_calc0", int'({ifc.mac_enb, ifc.tap_addr}), int'({1'b1, 7'd0}));
        @(negedge clk);
        #1;
        chk("c_calc1", int'({ifc.mac_enb, ifc.tap_addr}), int'({1'b1, 7'd1}));
        #2;
        rst_c = 1;
        #1;
        chk("c_rst_flags",
            int'({ifc.in_ready, ifc.mac_enb, ifc.out_valid, ifc.busy,
                  ifc.dp_rst, ifc.acc_clr}), int'(6'b000011));
        chk("c_rst_ch", int'({ifc.ch_sel, ifc.out_ch}), 0);
        chk("c_rst_tap", int'(ifc.tap_addr), 0);
        @(negedge clk);
        rst_c = 0;
        rises = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            #1;
            if (ifc.out_valid || ifc.busy) rises++;
        end
        chk("c_no_result", rises, 0);
        ifc.in_valid = 1;
        @(negedge clk);
        ifc.in_valid = 0;
        #1;
        chk("c_restart",
            int'({ifc.mac_enb, ifc.ch_sel, ifc.tap_addr}),
            int'({1'b1, 1'b0, 7'd0}));

        // D: single-tap filter, source and sink always ready
        ifd.in_valid = 1;
        ifd.out_ready = 1;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            #1;
            if (ifd.in_ready && ifd.in_valid) acc_cyc.push_back(i);
            if (ifd.out_valid) dch.push_back(int'(ifd.out_ch));
            if (ifd.mac_enb)
                chk($sformatf("d_calc%0d", i),
                    int'({ifd.last_tap, ifd.tap_addr}),
                    int'({1'b1, 7'd0}));
        end
        ifd.in_valid = 0;
        chk("d_accepts", int'(acc_cyc.size() >= 4), 1);
        if (acc_cyc.size() >= 4) begin
            chk("d_gap1", acc_cyc[1] - acc_cyc[0], 3);
            chk("d_gap2", acc_cyc[2] - acc_cyc[1], 3);
            chk("d_gap3", acc_cyc[3] - acc_cyc[2], 3);
        end
        chk("d_results", int'(dch.size() >= 2), 1);
        if (dch.size() >= 2) begin
            chk("d_och0", dch[0], 0);
            chk("d_och1", dch[1], 1);
        end

        prev_ov = ifa.out_valid;
        chk("a_final_idle", int'({prev_ov, ifa.in_ready}), 1);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule
